mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store controller between the MIPS datapath and the word-addressed data memory.
- Accepts one load or store request at a time: LB/LBU/LH/LHU/LW/SB/SH/SW.
- Drives the memory's addr/rd_en/wr_en/wr_data and sign/zero-extends read data.
- Memory side is word-granular, so sub-word stores use read-modify-write.

Parameters:
- ADDR_W, 32, width of request and memory address
- DATA_W, 32, data word width; fixed at 32, byte lanes assume 4 bytes

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load result, held until next response
- resp_err  out  1  misaligned-access flag, valid with resp_valid
- mem_addr  out  ADDR_W  word-aligned address {addr_q[31:2],2'b00}
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable (memory writes on posedge)
- mem_wr_data  out  DATA_W  registered full word to write
- mem_rd_data  in  DATA_W  combinational memory read data

Behaviour:
- Handshake: transfer occurs on the posedge where req_valid && req_ready. Request fields are latched into addr_q/size_q/we_q/uns_q/wdata_q. req_valid while busy is ignored and not queued.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0, and so on up to 3 for bits 31:24. Halfword lane is selected by addr[1].
- FSM is Moore, and mem_rd_en/mem_wr_en are decoded from the state register only.
  - IDLE: req_ready=1, mem_rd_en=0, mem_wr_en=0. On accept: load goes to LOAD; word store goes to STORE with mem_wr_data=req_wdata; byte/half store goes to RMW_RD; misaligned access with trap enabled goes to RESP with err_q=1.
  - LOAD: mem_rd_en=1. Select lane from mem_rd_data, extend per uns_q, register into resp_rdata. Next state RESP.
  - RMW_RD: mem_rd_en=1. Merge wdata_q low byte/half into the selected lane of mem_rd_data, register as mem_wr_data. Next state STORE.
  - STORE: mem_wr_en=1. Next state RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_err=err_q. Next state IDLE. req_ready=0 in this state.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - trapped misaligned access: 1 cycle
  - Minimum accept-to-accept spacing is latency+1.
- mem_addr is held stable from the accept edge through RESP. resp_rdata is unchanged by stores.
- Reset (any state, including mid-RMW): next state IDLE, pending request dropped with no response. mem_wr_en=0 in the cycle after the reset edge, so a partial RMW never writes.
- Reset values: req_ready=1 after the reset edge; resp_valid=0; resp_rdata=0; resp_err=0; mem_rd_en=0; mem_wr_en=0; mem_wr_data=0; mem_addr=0.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is misaligned. It produces no memory access (mem_rd_en/mem_wr_en stay 0), then RESP with resp_err=1. resp_rdata is unchanged.
- Undefined: misaligned low address bits are ignored (word ignores addr[1:0], halfword ignores addr[0]). The access proceeds normally and resp_err is tied 0.

Test Plan:
- Memory word 0x10 = 0x8899AABB. LB addr 0x10 -> resp_rdata=0xFFFFFFBB. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899. Each has resp_valid exactly 2 cycles after accept.
- SH addr 0x12 wdata 0xDEAD1234 -> one mem_rd_en cycle, then one mem_wr_en cycle with mem_wr_data=0x1234AABB. resp_valid 3 cycles after accept; a following LW 0x10 returns 0x1234AABB.
- SW addr 0x20 wdata 0xCAFEF00D -> no read cycle, mem_wr_en one cycle with mem_addr=0x20. LW 0x20 -> 0xCAFEF00D.
- LW addr 0x11 with macro -> resp_err=1 one cycle after accept, no mem enables. Without macro -> reads word 0x10 = 0x8899AABB, resp_err=0.
- SB 0x11 with reset asserted during the RMW_RD cycle -> no mem_wr_en ever, no resp_valid, req_ready=1 next cycle, word 0x10 unchanged.
- req_valid held high for 6 back-to-back LW requests -> accepts spaced 3 cycles apart, req_ready low while busy, every response in order.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store controller between the datapath and a
//               word-addressed data memory. Sub-word stores use a
//               read-modify-write; loads are lane-selected and extended.
//               Optional macro MEM_ACCESS_MISALIGN_TRAP_EN enables trapping
//               of misaligned halfword/word accesses.
// Revision    : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_STORE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [15:0]       r_wdata;

    logic              w_accept;
    logic              w_misalign;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic              r_err;

    // Reserved size 2'b11 behaves as a word.
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err   = r_err & resp_valid;
`else
    assign w_misalign = 1'b0;
    assign resp_err   = 1'b0;
`endif

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Moore outputs: enables and handshakes depend on the state register only.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_misalign) begin
                        w_state_nxt = S_RESP;
                    end else if (!req_we) begin
                        w_state_nxt = S_LOAD;
                    end else if (req_size[1]) begin
                        w_state_nxt = S_STORE;
                    end else begin
                        w_state_nxt = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                mem_rd_en   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RMW_RD: begin
                mem_rd_en   = 1'b1;
                w_state_nxt = S_STORE;
            end
            S_STORE: begin
                mem_wr_en   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Little-endian lane selection, extension and store merge.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rd_data[7:0];
            2'd1:    w_byte = mem_rd_data[15:8];
            2'd2:    w_byte = mem_rd_data[23:16];
            default: w_byte = mem_rd_data[31:24];
        endcase
        w_half = r_addr[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

        case (r_size)
            2'b00:   w_load = r_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = mem_rd_data;
        endcase

        w_merged = mem_rd_data;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0]  = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_wdata     <= 16'h0000;
            mem_wr_data <= '0;
            resp_rdata  <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            r_err       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_wdata <= req_wdata[15:0];
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                r_err   <= w_misalign;
`endif
                // Full-word stores skip the read phase entirely.
                if (req_we && req_size[1] && !w_misalign) begin
                    mem_wr_data <= req_wdata;
                end
            end
            if (r_state == S_LOAD) begin
                resp_rdata <= w_load;
            end
            if (r_state == S_RMW_RD) begin
                mem_wr_data <= w_merged;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a word memory model.
// Revision    : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Word memory model, preloaded once at start-up.
    logic [31:0] mem [0:63];
    logic        preload = 1'b1;
    assign mem_rd_data = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_wr_en) begin
            mem[mem_addr[7:2]] <= mem_wr_data;
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wdata;
        logic [31:0] waddr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    bit          mon_en = 1'b0;
    int          prev_acc = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: pops one expectation per response and checks the memory side.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) begin
                wr_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_wr_en", 32'(mem_wr_en), 32'h0);
                end else begin
                    check("mem_wr_data", mem_wr_data, q[0].wdata);
                    check("mem_wr_addr", mem_addr, q[0].waddr);
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), e.err);
                    check("latency", 32'(cycle - e.acc), 32'(e.lat));
                    check("rd_cycles", 32'(rd_cnt), 32'(e.rd));
                    check("wr_cycles", 32'(wr_cnt), 32'(e.wr));
                end
            end
            if (q.size() == 0) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input exp_t e, input bit keep, input bit push, input bit chk_sp);
        int waited;
        exp_t ee;
        ee = e;
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 at addr %h", addr);
            req_valid = 1'b0;
            return;
        end
        ee.acc = cycle;
        if (push) q.push_back(ee);
        if (chk_sp) check("accept_spacing", 32'(cycle - prev_acc), 32'd3);
        prev_acc = cycle;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] exp_data, input bit keep, input bit chk_sp);
        exp_t e;
        e.rdata = exp_data; e.err = 32'h0; e.lat = 2; e.rd = 1; e.wr = 0;
        e.wdata = 32'h0; e.waddr = 32'h0; e.acc = 0;
        last_rdata = exp_data;
        issue(1'b0, size, uns, addr, 32'h0, e, keep, 1'b1, chk_sp);
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_word);
        exp_t e;
        e.rdata = last_rdata; e.err = 32'h0;
        e.lat = (size == 2'b10) ? 2 : 3;
        e.rd  = (size == 2'b10) ? 0 : 1;
        e.wr = 1; e.wdata = exp_word; e.waddr = {addr[31:2], 2'b00}; e.acc = 0;
        issue(1'b1, size, 1'b0, addr, wdata, e, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   w;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        preload = 1'b0;
        mon_en = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        check("rst_mem_wr_data", mem_wr_data, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        ld(2'b00, 1'b0, 32'h10, 32'hFFFFFFBB, 1'b0, 1'b0);  // LB
        ld(2'b00, 1'b1, 32'h13, 32'h00000088, 1'b0, 1'b0);  // LBU
        ld(2'b01, 1'b0, 32'h12, 32'hFFFF8899, 1'b0, 1'b0);  // LH
        ld(2'b01, 1'b1, 32'h10, 32'h0000AABB, 1'b0, 1'b0);  // LHU
        ld(2'b01, 1'b0, 32'h10, 32'hFFFFAABB, 1'b0, 1'b0);  // LH negative

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        e.rdata = last_rdata; e.err = 32'h1; e.lat = 1; e.rd = 0; e.wr = 0;
        e.wdata = 32'h0; e.waddr = 32'h0; e.acc = 0;
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, e, 1'b0, 1'b1, 1'b0);
`else
        ld(2'b10, 1'b0, 32'h11, 32'h8899AABB, 1'b0, 1'b0);
`endif

        st(2'b01, 32'h12, 32'hDEAD1234, 32'h1234AABB);       // SH
        ld(2'b10, 1'b0, 32'h10, 32'h1234AABB, 1'b0, 1'b0);
        st(2'b10, 32'h20, 32'hCAFEF00D, 32'hCAFEF00D);       // SW
        ld(2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0);
        st(2'b00, 32'h21, 32'h00000055, 32'hCAFE550D);       // SB
        ld(2'b00, 1'b0, 32'h21, 32'h00000055, 1'b0, 1'b0);

        // Reset during the RMW read phase: nothing may be written or answered.
        w = 0;
        while (q.size() != 0 && w < 20) begin @(negedge clk); w++; end
        e.rdata = 32'h0; e.err = 32'h0; e.lat = 0; e.rd = 0; e.wr = 0;
        e.wdata = 32'h0; e.waddr = 32'h0; e.acc = 0;
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000FF, e, 1'b0, 1'b0, 1'b0);
        check("rmw_rd_en", 32'(mem_rd_en), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'h1);
        check("abort_wr_en", 32'(mem_wr_en), 32'h0);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_resp_rdata", resp_rdata, 32'h0);
        check("abort_mem_wr_data", mem_wr_data, 32'h0);
        repeat (4) @(negedge clk);
        last_rdata = 32'h0;
        ld(2'b10, 1'b0, 32'h10, 32'h1234AABB, 1'b0, 1'b0);

        // Back-to-back loads with req_valid held high.
        ld(2'b10, 1'b0, 32'h10, 32'h1234AABB, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) begin
            ld(2'b10, 1'b0, (i % 2 == 1) ? 32'h20 : 32'h10,
               (i % 2 == 1) ? 32'hCAFE550D : 32'h1234AABB, (i < 5), 1'b1);
        end

        w = 0;
        while (q.size() != 0 && w < 50) begin @(negedge clk); w++; end
        if (q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
